// File: rtl/cond_branch_unit_pkg.sv
// Shared types and constants for the LEGv8 conditional branch unit.
package cond_branch_unit_pkg;

    typedef enum logic [1:0] {
        BR_B    = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational LEGv8 condition-code evaluator over an NZCV value.
module cond_eval
    import cond_branch_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  nzcv_t      flags,
    output logic       cond_true
);

    logic n_eq_v;

    assign n_eq_v = (flags.n == flags.v);

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_EQ: cond_true = flags.z;
            COND_NE: cond_true = ~flags.z;
            COND_HS: cond_true = flags.c;
            COND_LO: cond_true = ~flags.c;
            COND_MI: cond_true = flags.n;
            COND_PL: cond_true = ~flags.n;
            COND_VS: cond_true = flags.v;
            COND_VC: cond_true = ~flags.v;
            COND_HI: cond_true = flags.c & ~flags.z;
            COND_LS: cond_true = ~(flags.c & ~flags.z);
            COND_GE: cond_true = n_eq_v;
            COND_LT: cond_true = ~n_eq_v;
            COND_GT: cond_true = ~flags.z & n_eq_v;
            COND_LE: cond_true = ~(~flags.z & n_eq_v);
            // NV behaves as AL on this architecture.
            COND_AL, COND_NV: cond_true = 1'b1;
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// EX-stage branch resolver: NZCV register, in-flight flag-setter tracking,
// and a registered taken/not-taken decision for B, B.cond, CBZ and CBNZ.
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter int unsigned MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flag_issue,
    input  logic       alu_valid,
    input  logic       set_flags,
    input  logic       negative,
    input  logic       zero,
    input  logic       overflow,
    input  logic       carry_out,
    input  logic       br_valid,
    input  logic [1:0] br_type,
    input  logic [3:0] br_cond,
    output logic       br_ready,
    output logic       taken_valid,
    output logic       taken,
    output logic [3:0] flags_q,
    output logic       pend_err
);

    localparam int unsigned CNT_W = (MAX_PEND < 2) ? 1 : $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    nzcv_t            flags_r;
    nzcv_t            alu_flags;
    nzcv_t            eff_flags;
    logic [CNT_W-1:0] pend_cnt;
    logic             flag_wr;
    logic             cond_true;
    logic             decision;
    logic             accept;
    br_type_e         br_kind;

    assign flag_wr   = alu_valid & set_flags;
    assign alu_flags = '{n: negative, z: zero, c: carry_out, v: overflow};
    assign br_kind   = br_type_e'(br_type);

    // A flag write in the same cycle is bypassed so B.cond sees the new NZCV.
    assign eff_flags = flag_wr ? alu_flags : flags_r;

    cond_eval u_cond_eval (
        .cond      (br_cond),
        .flags     (eff_flags),
        .cond_true (cond_true)
    );

    always_comb begin
        br_ready = 1'b0;
        decision = 1'b0;
        case (br_kind)
            BR_B: begin
                br_ready = 1'b1;
                decision = 1'b1;
            end
            BR_COND: begin
                br_ready = (pend_cnt == '0) || ((pend_cnt == CNT_ONE) && flag_wr);
                decision = cond_true;
            end
            BR_CBZ: begin
                br_ready = alu_valid;
                decision = zero;
            end
            BR_CBNZ: begin
                br_ready = alu_valid;
                decision = ~zero;
            end
            default: begin
                br_ready = 1'b0;
                decision = 1'b0;
            end
        endcase
    end

    assign accept = br_valid & br_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_r     <= '0;
            pend_cnt    <= '0;
            pend_err    <= 1'b0;
            taken_valid <= 1'b0;
            taken       <= 1'b0;
        end else begin
            if (flag_wr) begin
                flags_r <= alu_flags;
            end

            // Issue and retire together cancel, even at the saturation limit.
            if (flag_issue && !flag_wr) begin
                if (pend_cnt == CNT_MAX) begin
                    pend_err <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + CNT_ONE;
                end
            end else if (flag_wr && !flag_issue) begin
                if (pend_cnt == '0) begin
                    pend_err <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt - CNT_ONE;
                end
            end

            taken_valid <= accept;
            taken       <= accept & decision;
        end
    end

    assign flags_q = flags_r;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit: a reference model predicts br_ready,
// NZCV, pend_err and each branch decision; decisions queue until presented.
module tb_cond_branch_unit;

    logic       clk;
    logic       reset_n;
    logic       flag_issue;
    logic       alu_valid;
    logic       set_flags;
    logic       negative;
    logic       zero;
    logic       overflow;
    logic       carry_out;
    logic       br_valid;
    logic [1:0] br_type;
    logic [3:0] br_cond;
    logic       br_ready;
    logic       taken_valid;
    logic       taken;
    logic [3:0] flags_q;
    logic       pend_err;

    int unsigned n_checks   = 0;
    int unsigned n_failures = 0;

    logic       exp_q[$];
    logic [3:0] m_flags;
    int         m_cnt;
    logic       m_err;
    bit         armed = 1'b0;

    cond_branch_unit #(.MAX_PEND(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flag_issue  (flag_issue),
        .alu_valid   (alu_valid),
        .set_flags   (set_flags),
        .negative    (negative),
        .zero        (zero),
        .overflow    (overflow),
        .carry_out   (carry_out),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_cond     (br_cond),
        .br_ready    (br_ready),
        .taken_valid (taken_valid),
        .taken       (taken),
        .flags_q     (flags_q),
        .pend_err    (pend_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference condition table; f = {N,Z,C,V}.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    always @(negedge clk) begin
        logic       wr;
        logic [3:0] eff;
        logic       m_ready;
        logic       m_dec;
        wr  = alu_valid && set_flags;
        eff = wr ? {negative, zero, carry_out, overflow} : m_flags;
        case (br_type)
            2'b00:   begin m_ready = 1'b1;      m_dec = 1'b1; end
            2'b01:   begin m_ready = (m_cnt == 0) || (m_cnt == 1 && wr); m_dec = model_cond(br_cond, eff); end
            2'b10:   begin m_ready = alu_valid; m_dec = zero; end
            default: begin m_ready = alu_valid; m_dec = !zero; end
        endcase

        if (armed) begin
            check("flags_q", {28'd0, flags_q}, {28'd0, m_flags});
            check("pend_err", {31'd0, pend_err}, {31'd0, m_err});
            if (exp_q.size() > 0) begin
                logic e;
                e = exp_q.pop_front();
                check("taken_valid", {31'd0, taken_valid}, 32'd1);
                check("taken", {31'd0, taken}, {31'd0, e});
            end else begin
                check("taken_valid_idle", {31'd0, taken_valid}, 32'd0);
            end
            if (br_valid) check("br_ready", {31'd0, br_ready}, {31'd0, m_ready});
        end

        if (!reset_n) begin
            exp_q.delete();
            m_flags = 4'b0000;
            m_cnt   = 0;
            m_err   = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            if (br_valid && br_ready) exp_q.push_back(m_dec);
            if (wr) m_flags = {negative, zero, carry_out, overflow};
            if (flag_issue && !wr) begin
                if (m_cnt == 3) m_err = 1'b1; else m_cnt++;
            end else if (wr && !flag_issue) begin
                if (m_cnt == 0) m_err = 1'b1; else m_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flag_issue = 1'b0;
        alu_valid  = 1'b0;
        set_flags  = 1'b0;
        {negative, zero, carry_out, overflow} = 4'b0000;
        br_valid   = 1'b0;
        br_type    = 2'b00;
        br_cond    = 4'b0000;
    endtask

    task automatic alu_write(input logic [3:0] nzcv);
        alu_valid = 1'b1;
        set_flags = 1'b1;
        {negative, zero, carry_out, overflow} = nzcv;
    endtask

    task automatic branch(input logic [1:0] t, input logic [3:0] c);
        br_valid = 1'b1;
        br_type  = t;
        br_cond  = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        check("rst_flags", {28'd0, flags_q}, 32'd0);
        check("rst_tv", {31'd0, taken_valid}, 32'd0);
        check("rst_err", {31'd0, pend_err}, 32'd0);

        // Unconditional branch.
        branch(2'b00, 4'b0000);
        #2 check("b_ready", {31'd0, br_ready}, 32'd1);
        tick(); idle();
        check("b_tv", {31'd0, taken_valid}, 32'd1);
        check("b_taken", {31'd0, taken}, 32'd1);

        // ADDS 7fff..f + 7fff..f: N=1 Z=0 C=0 V=1.
        flag_issue = 1'b1; tick(); idle();
        alu_write(4'b1001); tick(); idle();
        check("adds_flags", {28'd0, flags_q}, 32'h9);
        branch(2'b01, 4'b1010);
        #2 check("ge_ready", {31'd0, br_ready}, 32'd1);
        tick();
        check("ge_taken", {31'd0, taken}, 32'd1);
        br_cond = 4'b1011;
        tick(); idle();
        check("lt_taken", {31'd0, taken}, 32'd0);

        // Stall with two flag setters in flight, then bypass on the second write.
        flag_issue = 1'b1; tick(); tick(); idle();
        branch(2'b01, 4'b0000);
        #2 check("stall_cnt2", {31'd0, br_ready}, 32'd0);
        tick();
        alu_write(4'b0000);
        #2 check("stall_cnt2_wr", {31'd0, br_ready}, 32'd0);
        tick();
        alu_write(4'b0110);
        #2 check("bypass_ready", {31'd0, br_ready}, 32'd1);
        tick(); idle();
        check("bypass_tv", {31'd0, taken_valid}, 32'd1);
        check("bypass_taken", {31'd0, taken}, 32'd1);

        // CBZ / CBNZ on the ALU pass-through zero flag.
        branch(2'b10, 4'b0000);
        #2 check("cbz_stall", {31'd0, br_ready}, 32'd0);
        tick();
        alu_valid = 1'b1; zero = 1'b1;
        #2 check("cbz_ready", {31'd0, br_ready}, 32'd1);
        tick();
        check("cbz_taken", {31'd0, taken}, 32'd1);
        br_type = 2'b11; zero = 1'b0;
        tick();
        check("cbnz_nz_taken", {31'd0, taken}, 32'd1);
        zero = 1'b1;
        tick(); idle();
        check("cbnz_z_taken", {31'd0, taken}, 32'd0);

        // Full sweep: each NZCV loaded (issue+write net zero, with a bypassed
        // B.cond), then all 16 conditions evaluated from flags_q.
        for (int f = 0; f < 16; f++) begin
            flag_issue = 1'b1;
            alu_write(4'(f));
            branch(2'b01, 4'(f));
            tick(); idle();
            for (int c = 0; c < 16; c++) begin
                branch(2'b01, 4'(c));
                tick();
            end
            idle();
        end
        tick();

        // Counter overflow: fourth issue saturates at 3 and sets pend_err.
        flag_issue = 1'b1;
        repeat (3) tick();
        check("err_before_ovf", {31'd0, pend_err}, 32'd0);
        tick(); idle();
        check("err_after_ovf", {31'd0, pend_err}, 32'd1);
        branch(2'b01, 4'b1110);
        alu_write(4'b0000);
        #2 check("cnt3_stall", {31'd0, br_ready}, 32'd0);
        tick(); idle();

        // Reset discards a branch accepted in the reset cycle.
        reset_n = 1'b0;
        branch(2'b00, 4'b0000);
        tick(); idle();
        tick();
        reset_n = 1'b1;
        check("rst_discard_tv", {31'd0, taken_valid}, 32'd0);
        check("rst_err_clear", {31'd0, pend_err}, 32'd0);

        // Underflow: flag write with nothing pending still updates flags_q.
        alu_write(4'b1010);
        tick(); idle();
        check("err_underflow", {31'd0, pend_err}, 32'd1);
        check("underflow_flags", {28'd0, flags_q}, 32'ha);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
